// File: rtl/wbdepp_pkg.sv
// Shared constants for the DEPP-to-Wishbone bridge: register map pointers,
// status bit positions and the bridge FSM state encoding.
package wbdepp_pkg;

  localparam logic [7:0] PTR_ADDR0  = 8'h00;
  localparam logic [7:0] PTR_DATA0  = 8'h04;
  localparam logic [7:0] PTR_STATUS = 8'h08;
  localparam logic [7:0] PTR_CTRL   = 8'h09;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_ERR  = 1;
  localparam int unsigned ST_INT  = 2;
  localparam int unsigned ST_TMO  = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WB_REQ,
    S_WB_WAIT
  } state_t;

endpackage

// File: rtl/wbdepp_bridge_sync.sv
// Multi-flop synchroniser for one asynchronous DEPP control line, with
// rising/falling edge detection on the synchronised level. Idles high.
module depp_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign fall  = prev & ~level;
  assign rise  = ~prev & level;

endmodule

// File: rtl/wbdepp_bridge.sv
// DEPP (EPP-style) host port to pipelined Wishbone master with a small
// pointer-addressed register file. Optional bus watchdog: WBDEPP_TIMEOUT_EN.
module wbdepp_bridge
  import wbdepp_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_astb_n,
  input  logic            i_dstb_n,
  input  logic            i_write_n,
  input  logic [7:0]      i_depp,
  output logic [7:0]      o_depp,
  output logic            o_wait,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  input  logic            i_int
);

  localparam int unsigned NB        = DW / 8;
  localparam logic [7:0]  PTR_DLAST = PTR_DATA0 + 8'(NB - 1);

  state_t state, state_nx;

  logic [7:0] ptr;
  logic       ctrl_inc;
  logic       st_err, st_int, st_tmo;

  logic ast_lvl, ast_fall, ast_rise_unused;
  logic dst_lvl, dst_fall, dst_rise_unused;
  logic wrn_lvl, wrn_fall_unused, wrn_rise_unused;

  depp_sync #(.STAGES(SYNC_STAGES)) u_astb (
    .clk(i_clk), .reset(i_reset), .pin(i_astb_n),
    .level(ast_lvl), .fall(ast_fall), .rise(ast_rise_unused)
  );
  depp_sync #(.STAGES(SYNC_STAGES)) u_dstb (
    .clk(i_clk), .reset(i_reset), .pin(i_dstb_n),
    .level(dst_lvl), .fall(dst_fall), .rise(dst_rise_unused)
  );
  depp_sync #(.STAGES(SYNC_STAGES)) u_wrn (
    .clk(i_clk), .reset(i_reset), .pin(i_write_n),
    .level(wrn_lvl), .fall(wrn_fall_unused), .rise(wrn_rise_unused)
  );

  logic idle, in_bus, host_wr, ast_go, dst_go;
  logic is_addr, is_data, launch_wr, launch_rd;
  logic bus_ack, bus_err, timeout_hit;

  assign idle    = (state == S_IDLE);
  assign in_bus  = (state == S_WB_REQ) || (state == S_WB_WAIT);
  assign host_wr = ~wrn_lvl;
  // An address strobe edge wins over a coincident data strobe edge.
  assign ast_go  = idle && ast_fall;
  assign dst_go  = idle && dst_fall && !ast_fall;

  assign is_addr   = (ptr >= PTR_ADDR0) && (ptr < PTR_DATA0);
  assign is_data   = (ptr >= PTR_DATA0) && (ptr <= PTR_DLAST);
  assign launch_wr = dst_go && host_wr && (ptr == PTR_DLAST);
  assign launch_rd = dst_go && !host_wr && (ptr == PTR_DATA0);

  assign bus_err = (state == S_WB_WAIT) && i_wb_err;
  assign bus_ack = (state == S_WB_WAIT) && i_wb_ack && !i_wb_err;

`ifdef WBDEPP_TIMEOUT_EN
  localparam int unsigned TCW = ($clog2(TIMEOUT_CYC + 1) > 11) ? $clog2(TIMEOUT_CYC + 1) : 11;
  logic [TCW-1:0] tmo_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || !in_bus) tmo_cnt <= '0;
    else                    tmo_cnt <= tmo_cnt + TCW'(1);
  end

  assign timeout_hit = in_bus && !bus_ack && !bus_err && (tmo_cnt == TCW'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYC == 0);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_wait   = 1'b0;
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_sel = '1;
    unique case (state)
      S_IDLE: begin
        if (launch_wr || launch_rd)  state_nx = S_WB_REQ;
        else if (ast_go || dst_go)   state_nx = S_HOLD;
      end
      S_WB_REQ: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        if (timeout_hit)      state_nx = S_HOLD;
        else if (!i_wb_stall) state_nx = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        o_wb_cyc = 1'b1;
        if (bus_ack || bus_err || timeout_hit) state_nx = S_HOLD;
      end
      S_HOLD: begin
        o_wait = 1'b1;
        if (ast_lvl && dst_lvl) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Register file read mux plus byte-merged next values for host writes.
  logic [7:0]    rd_byte;
  logic [31:0]   addr32, addr_mod;
  logic [DW-1:0] data_mod;
  int unsigned   abyte, dbyte;

  always_comb begin
    rd_byte  = '0;
    addr32   = 32'(o_wb_addr);
    addr_mod = addr32;
    data_mod = o_wb_data;
    abyte    = 32'd3 - 32'(ptr[1:0]);
    dbyte    = 0;
    if (is_addr) begin
      rd_byte                 = addr32[abyte*8 +: 8];
      addr_mod[abyte*8 +: 8]  = i_depp;
    end else if (is_data) begin
      dbyte                   = NB - 1 - 32'(ptr - PTR_DATA0);
      rd_byte                 = o_wb_data[dbyte*8 +: 8];
      data_mod[dbyte*8 +: 8]  = i_depp;
    end else if (ptr == PTR_STATUS) begin
      rd_byte = {4'b0000, st_tmo, st_int, st_err, in_bus};
    end else if (ptr == PTR_CTRL) begin
      rd_byte = {7'b0000000, ctrl_inc};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr       <= '0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_wb_we   <= 1'b0;
      o_depp    <= '0;
      ctrl_inc  <= 1'b0;
      st_err    <= 1'b0;
      st_int    <= 1'b0;
      st_tmo    <= 1'b0;
    end else begin
      if (ast_go) begin
        if (host_wr) ptr    <= i_depp;
        else         o_depp <= ptr;
      end
      if (dst_go) begin
        if (host_wr) begin
          if (is_addr) o_wb_addr <= addr_mod[AW-1:0];
          if (is_data) o_wb_data <= data_mod;
          if (ptr == PTR_STATUS) begin
            st_err <= st_err & ~i_depp[ST_ERR];
            st_int <= st_int & ~i_depp[ST_INT];
            st_tmo <= st_tmo & ~i_depp[ST_TMO];
          end
          if (ptr == PTR_CTRL) ctrl_inc <= i_depp[0];
        end else if (!launch_rd) begin
          o_depp <= rd_byte;
        end
      end
      if (launch_wr) o_wb_we <= 1'b1;
      if (launch_rd) o_wb_we <= 1'b0;
      if (bus_ack) begin
        if (!o_wb_we) begin
          o_wb_data <= i_wb_data;
          o_depp    <= i_wb_data[DW-1 -: 8];
        end
        if (ctrl_inc) o_wb_addr <= o_wb_addr + AW'(1);
      end
      if (bus_err || timeout_hit) begin
        st_err <= 1'b1;
        if (!o_wb_we) begin
          o_wb_data <= '1;
          o_depp    <= '1;
        end
      end
      if (timeout_hit) st_tmo <= 1'b1;
      // Placed after the W1C so a live interrupt re-latches immediately.
      if (i_int) st_int <= 1'b1;
    end
  end

endmodule
